// File: rtl/avr_pkg.sv
// Shared AVR constants: two-word opcode patterns, NOP encoding, default reset vector.
package avr_pkg;

   localparam logic [15:0] LDS_STS_MASK  = 16'hFC0F;
   localparam logic [15:0] LDS_STS_VAL   = 16'h9000;
   localparam logic [15:0] JMP_CALL_MASK = 16'hFE0C;
   localparam logic [15:0] JMP_CALL_VAL  = 16'h940C;

   localparam logic [15:0] NOP = 16'h0000;

   localparam int unsigned DEFAULT_RESET_VEC = 0;

   function automatic logic is_two_word(input logic [15:0] w);
      return ((w & LDS_STS_MASK) == LDS_STS_VAL) || ((w & JMP_CALL_MASK) == JMP_CALL_VAL);
   endfunction

endpackage

// File: rtl/avr_fetch_q.sv
// Three-entry shifting word queue of {word, address}; entry 0 is always the head.
module avr_fetch_q
   import avr_pkg::*;
#(
   parameter int              PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            i_push,
   input  logic [15:0]     i_push_word,
   input  logic [PC_W-1:0] i_push_addr,
   input  logic            i_pop1,
   input  logic            i_pop2,
   input  logic            i_clear,
   output logic [1:0]      o_count,
   output logic [15:0]     o_head_word,
   output logic [PC_W-1:0] o_head_addr,
   output logic [15:0]     o_sec_word
);

   logic [15:0]     r_word [3];
   logic [PC_W-1:0] r_addr [3];
   logic [1:0]      r_count;

   logic [15:0]     w_word_nxt [3];
   logic [PC_W-1:0] w_addr_nxt [3];
   logic [1:0]      w_pops;
   logic [1:0]      w_base;

   assign w_pops = i_pop2 ? 2'd2 : (i_pop1 ? 2'd1 : 2'd0);
   // Occupancy after the pop; an incoming word lands right behind the survivors.
   assign w_base = r_count - w_pops;

   always_comb begin
      logic [1:0] v_src;
      v_src = '0;
      for (int i = 0; i < 3; i++) begin
         w_word_nxt[i] = r_word[i];
         w_addr_nxt[i] = r_addr[i];
         if (i + int'(w_pops) < 3) begin
            v_src         = 2'(i) + w_pops;
            w_word_nxt[i] = r_word[v_src];
            w_addr_nxt[i] = r_addr[v_src];
         end
         if (i_push && (w_base == 2'(i))) begin
            w_word_nxt[i] = i_push_word;
            w_addr_nxt[i] = i_push_addr;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_count <= '0;
         for (int i = 0; i < 3; i++) begin
            r_word[i] <= NOP;
            r_addr[i] <= RESET_VEC;
         end
      end else if (i_clear) begin
         r_count <= '0;
      end else begin
         r_count <= w_base + {1'b0, i_push};
         for (int i = 0; i < 3; i++) begin
            r_word[i] <= w_word_nxt[i];
            r_addr[i] <= w_addr_nxt[i];
         end
      end
   end

   assign o_count     = r_count;
   assign o_head_word = r_word[0];
   assign o_head_addr = r_addr[0];
   assign o_sec_word  = r_word[1];

endmodule

// File: rtl/avr_fetch.sv
// AVR instruction fetch: owns the fetch PC, issues program-memory reads,
// assembles one/two-word instructions and hands them to the CPU over valid/ready.
module avr_fetch
   import avr_pkg::*;
#(
   parameter int              PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEFAULT_RESET_VEC)
) (
   input  logic            CLK,
   input  logic            RST_N,
   output logic            pm_en,
   output logic [PC_W-1:0] pm_addr,
   input  logic [15:0]     pm_rdata,
   input  logic            flush,
   input  logic [PC_W-1:0] flush_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [15:0]     instr,
   output logic [15:0]     instr_ext,
   output logic [PC_W-1:0] instr_pc
);

   logic [PC_W-1:0] r_fpc;
   logic [PC_W-1:0] r_req_addr;
   logic            r_inflight;

   logic [1:0]      w_count;
   logic [15:0]     w_head_word;
   logic [PC_W-1:0] w_head_addr;
   logic [15:0]     w_sec_word;
   logic            w_two;
   logic            w_xfer;
   logic            w_push;

   assign w_two       = is_two_word(w_head_word);
   assign instr_valid = w_two ? (w_count >= 2'd2) : (w_count != 2'd0);
   assign w_xfer      = instr_valid && instr_ready;

   // Gated by RST_N so the request line is quiet for the whole reset interval.
   assign pm_en   = RST_N && !flush && (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd3);
   assign pm_addr = r_fpc;

   // A read in flight during a flush returns into a cleared queue and is dropped.
   assign w_push = r_inflight && !flush;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_fpc      <= RESET_VEC;
         r_req_addr <= RESET_VEC;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= pm_en;
         if (pm_en) begin
            r_req_addr <= r_fpc;
         end
         if (flush) begin
            r_fpc <= flush_pc;
         end else if (pm_en) begin
            r_fpc <= r_fpc + 1'b1;
         end
      end
   end

   avr_fetch_q #(
      .PC_W      (PC_W),
      .RESET_VEC (RESET_VEC)
   ) u_q (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .i_push      (w_push),
      .i_push_word (pm_rdata),
      .i_push_addr (r_req_addr),
      .i_pop1      (w_xfer && !w_two),
      .i_pop2      (w_xfer && w_two),
      .i_clear     (flush),
      .o_count     (w_count),
      .o_head_word (w_head_word),
      .o_head_addr (w_head_addr),
      .o_sec_word  (w_sec_word)
   );

   assign instr     = w_head_word;
   assign instr_ext = w_two ? w_sec_word : 16'h0000;
   assign instr_pc  = w_head_addr;

endmodule

// File: tb/tb_avr_fetch.sv
// Bench for avr_fetch: cycle-exact vector table, hand-written flush/wrap/reset
// sequences, then randomized traffic against an instruction-stream reference model.
module tb_avr_fetch;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        pm_en;
   logic [15:0] pm_addr;
   logic [15:0] pm_rdata = 16'h0000;
   logic        flush = 1'b0;
   logic [15:0] flush_pc = 16'h0000;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [15:0] instr;
   logic [15:0] instr_ext;
   logic [15:0] instr_pc;

   logic [15:0] mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (pm_en) pm_rdata <= mem[pm_addr];
   end

   avr_fetch #(.PC_W(16), .RESET_VEC(16'h0000)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .pm_en       (pm_en),
      .pm_addr     (pm_addr),
      .pm_rdata    (pm_rdata),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_ext   (instr_ext),
      .instr_pc    (instr_pc)
   );

   typedef struct {
      logic        rdy;
      logic        chk_f;
      logic        e_pm_en;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic [15:0] e_ext;
      logic [15:0] e_pc;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic rdy, input logic cf, input logic pe,
                               input logic [15:0] pa, input logic v,
                               input logic [15:0] i, input logic [15:0] e,
                               input logic [15:0] p);
      vec_t r;
      r.rdy = rdy; r.chk_f = cf; r.e_pm_en = pe; r.e_addr = pa;
      r.e_valid = v; r.e_instr = i; r.e_ext = e; r.e_pc = p;
      return r;
   endfunction

   // AVR two-word opcodes: LDS/STS and JMP/CALL.
   function automatic logic two_word(input logic [15:0] w);
      return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
   endfunction

   function automatic logic [15:0] rnd_word();
      logic [31:0] r;
      logic [15:0] x;
      r = $urandom;
      x = r[31:16];
      if (r[2:0] == 3'd0) return (x & 16'h03F0) | 16'h9000;
      if (r[2:0] == 3'd1) return (x & 16'h01F3) | 16'h940C;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic log_xfer();
      if (instr_valid && instr_ready)
         $display("[TB] t=%0t xfer pc=%h instr=%h ext=%h", $time, instr_pc, instr, instr_ext);
   endtask

   // Called at the start of a cycle with inputs set; waits for instr_valid within a bound.
   task automatic wait_valid(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (instr_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      chk({name, "_timeout"}, 32'(ok), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] model_pc;
      logic [15:0] e_w;
      logic [15:0] e_x;
      logic [15:0] p1;
      logic        rdy;
      logic        fl;
      logic [15:0] fpc;
      logic        prev_fl;
      int          xfers;

      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
      mem[0]  = 16'hE0A4; mem[1]  = 16'h50A1; mem[2]  = 16'h50A2; mem[3]  = 16'h0000;
      mem[4]  = 16'h9100; mem[5]  = 16'h0100; mem[6]  = 16'h1234; mem[7]  = 16'h2345;
      mem[8]  = 16'h3456; mem[9]  = 16'h4567; mem[10] = 16'h5678;
      mem[16'h10] = 16'h940C; mem[16'h11] = 16'h0020;
      mem[16'h20] = 16'hE0B1;

      //            rdy cf pe addr  v  instr     ext       pc
      tbl[0]  = mk(1, 1, 1, 16'd0,  0, 16'h0000, 16'h0000, 16'd0);
      tbl[1]  = mk(1, 0, 1, 16'd1,  0, 16'h0000, 16'h0000, 16'd0);
      tbl[2]  = mk(1, 1, 1, 16'd2,  1, 16'hE0A4, 16'h0000, 16'd0);
      tbl[3]  = mk(1, 1, 1, 16'd3,  1, 16'h50A1, 16'h0000, 16'd1);
      tbl[4]  = mk(1, 1, 1, 16'd4,  1, 16'h50A2, 16'h0000, 16'd2);
      tbl[5]  = mk(1, 1, 1, 16'd5,  1, 16'h0000, 16'h0000, 16'd3);
      tbl[6]  = mk(1, 0, 1, 16'd6,  0, 16'h0000, 16'h0000, 16'd0);
      tbl[7]  = mk(1, 1, 0, 16'd7,  1, 16'h9100, 16'h0100, 16'd4);
      tbl[8]  = mk(0, 1, 1, 16'd7,  1, 16'h1234, 16'h0000, 16'd6);
      tbl[9]  = mk(0, 1, 1, 16'd8,  1, 16'h1234, 16'h0000, 16'd6);
      tbl[10] = mk(0, 1, 0, 16'd9,  1, 16'h1234, 16'h0000, 16'd6);
      tbl[11] = mk(0, 1, 0, 16'd9,  1, 16'h1234, 16'h0000, 16'd6);
      tbl[12] = mk(0, 1, 0, 16'd9,  1, 16'h1234, 16'h0000, 16'd6);
      tbl[13] = mk(1, 1, 0, 16'd9,  1, 16'h1234, 16'h0000, 16'd6);
      tbl[14] = mk(1, 1, 1, 16'd9,  1, 16'h2345, 16'h0000, 16'd7);
      tbl[15] = mk(1, 1, 1, 16'd10, 1, 16'h3456, 16'h0000, 16'd8);
      tbl[16] = mk(1, 1, 1, 16'd11, 1, 16'h4567, 16'h0000, 16'd9);
      tbl[17] = mk(1, 1, 1, 16'd12, 1, 16'h5678, 16'h0000, 16'd10);

      repeat (3) @(negedge CLK);
      RST_N = 1'b1;

      // Reset fetch, streaming, two-word, backpressure
      for (int k = 0; k < 18; k++) begin
         instr_ready = tbl[k].rdy;
         #1;
         chk($sformatf("tbl%0d_pm_en", k), 32'(pm_en), 32'(tbl[k].e_pm_en));
         chk($sformatf("tbl%0d_pm_addr", k), 32'(pm_addr), 32'(tbl[k].e_addr));
         chk($sformatf("tbl%0d_valid", k), 32'(instr_valid), 32'(tbl[k].e_valid));
         if (tbl[k].chk_f) begin
            chk($sformatf("tbl%0d_instr", k), 32'(instr), 32'(tbl[k].e_instr));
            chk($sformatf("tbl%0d_ext", k), 32'(instr_ext), 32'(tbl[k].e_ext));
            chk($sformatf("tbl%0d_pc", k), 32'(instr_pc), 32'(tbl[k].e_pc));
         end
         log_xfer();
         @(negedge CLK);
      end

      // Flush to a JMP while a read is in flight
      instr_ready = 1'b1; flush = 1'b1; flush_pc = 16'h0010;
      #1;
      chk("flush_pm_en_low", 32'(pm_en), 32'd0);
      log_xfer();
      @(negedge CLK);
      flush = 1'b0;
      #1;
      chk("flush_f1_valid", 32'(instr_valid), 32'd0);
      chk("flush_f1_pm_en", 32'(pm_en), 32'd1);
      chk("flush_f1_addr", 32'(pm_addr), 32'h10);
      wait_valid("flush_jmp");
      chk("flush_jmp_instr", 32'(instr), 32'h940C);
      chk("flush_jmp_ext", 32'(instr_ext), 32'h0020);
      chk("flush_jmp_pc", 32'(instr_pc), 32'h10);
      log_xfer();
      @(negedge CLK);

      // Flush to a one-word opcode: exact f+3 latency
      flush = 1'b1; flush_pc = 16'h0020;
      #1; log_xfer();
      @(negedge CLK);
      flush = 1'b0;
      #1; chk("flush2_f1_valid", 32'(instr_valid), 32'd0);
      @(negedge CLK);
      #1; chk("flush2_f2_valid", 32'(instr_valid), 32'd0);
      @(negedge CLK);
      #1;
      chk("flush2_f3_valid", 32'(instr_valid), 32'd1);
      chk("flush2_f3_instr", 32'(instr), 32'hE0B1);
      chk("flush2_f3_pc", 32'(instr_pc), 32'h20);
      log_xfer();
      @(negedge CLK);

      // STS straddling the address wrap
      mem[16'hFFFF] = 16'h9200; mem[0] = 16'h0060; mem[1] = 16'h1111;
      flush = 1'b1; flush_pc = 16'hFFFF;
      #1; log_xfer();
      @(negedge CLK);
      flush = 1'b0;
      wait_valid("wrap_sts");
      chk("wrap_instr", 32'(instr), 32'h9200);
      chk("wrap_ext", 32'(instr_ext), 32'h0060);
      chk("wrap_pc", 32'(instr_pc), 32'hFFFF);
      log_xfer();
      @(negedge CLK);
      wait_valid("wrap_next");
      chk("wrap_next_pc", 32'(instr_pc), 32'h0001);
      chk("wrap_next_instr", 32'(instr), 32'h1111);
      log_xfer();
      @(negedge CLK);
      repeat (3) @(negedge CLK);

      // Reset asserted mid-stream
      #2;
      RST_N = 1'b0;
      #1;
      chk("rst_pm_en", 32'(pm_en), 32'd0);
      chk("rst_pm_addr", 32'(pm_addr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_ext", 32'(instr_ext), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      chk("rst_rel_pm_en", 32'(pm_en), 32'd1);
      chk("rst_rel_addr", 32'(pm_addr), 32'd0);
      @(negedge CLK);
      #1; chk("rst_rel_c1_valid", 32'(instr_valid), 32'd0);
      @(negedge CLK);
      #1;
      chk("rst_rel_c2_valid", 32'(instr_valid), 32'd1);
      chk("rst_rel_c2_instr", 32'(instr), 32'h0060);
      chk("rst_rel_c2_pc", 32'(instr_pc), 32'd0);
      log_xfer();
      @(negedge CLK);

      // Randomized traffic against the instruction-stream model
      for (int a = 0; a < 65536; a++) mem[a] = rnd_word();
      model_pc = 16'h0000;
      prev_fl  = 1'b0;
      xfers    = 0;
      for (int c = 0; c < 3000; c++) begin
         rdy = ($urandom_range(0, 9) < 7);
         fl  = (c == 0) || ($urandom_range(0, 29) == 0);
         fpc = 16'($urandom);
         instr_ready = rdy; flush = fl; flush_pc = fpc;
         #1;
         if (fl) chk("rnd_flush_pm_en", 32'(pm_en), 32'd0);
         if (prev_fl) chk("rnd_post_flush_valid", 32'(instr_valid), 32'd0);
         if (c != 0 && instr_valid && rdy) begin
            e_w = mem[model_pc];
            p1  = model_pc + 16'd1;
            e_x = two_word(e_w) ? mem[p1] : 16'h0000;
            chk("rnd_pc", 32'(instr_pc), 32'(model_pc));
            chk("rnd_instr", 32'(instr), 32'(e_w));
            chk("rnd_ext", 32'(instr_ext), 32'(e_x));
            log_xfer();
            model_pc = model_pc + (two_word(e_w) ? 16'd2 : 16'd1);
            xfers++;
         end
         if (fl) model_pc = fpc;
         prev_fl = fl;
         @(negedge CLK);
      end
      flush = 1'b0;
      chk("rnd_liveness", 32'(xfers >= 500), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
